gate_mux_arbiter: RTL

//  Shares one mux-based universal gate unit among N requesters. Each requester posts an

---
 rtl/gate_mux_pkg.sv | 19 +
 rtl/gate_mux_arbiter_if.sv | 29 ++
 rtl/gate_mux8_unit.sv | 26 ++
 rtl/gate_mux_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gate_mux_pkg.sv
// Shared definitions for the gate-mux arbiter: opcode values and FSM state encoding.
package gate_mux_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_mux_arbiter_if.sv
// Requester-side bus of the gate-mux arbiter: per-requester request/operands plus shared result.
interface gate_mux_arbiter_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) ();

  localparam int GID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [3*N-1:0]   op;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [N-1:0]     ack;
  logic             y;
  logic             busy;
  logic [GID_W-1:0] grant_id;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output req, op, a, b,
    input  ack, y, busy, grant_id, done_cnt
  );

  modport slave (
    input  req, op, a, b,
    output ack, y, busy, grant_id, done_cnt
  );

endinterface

// File: rtl/gate_mux8_unit.sv
// Combinational universal gate: an 8:1 mux picks one of eight 2-input gate functions by opcode.
module gate_mux8_unit
  import gate_mux_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  logic [7:0] fn;

  always_comb begin
    fn          = '0;
    fn[OP_AND]  = a & b;
    fn[OP_OR]   = a | b;
    fn[OP_NOT]  = ~a;
    fn[OP_NAND] = ~(a & b);
    fn[OP_NOR]  = ~(a | b);
    fn[OP_XOR]  = a ^ b;
    fn[OP_XNOR] = ~(a ^ b);
    fn[OP_BUF]  = a;
    y           = fn[op];
  end

endmodule

// File: rtl/gate_mux_arbiter.sv
// Round-robin arbiter sharing one gate_mux8_unit among N requesters; IDLE->EXEC->ACK per operation.
module gate_mux_arbiter
  import gate_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  gate_mux_arbiter_if.slave  bus
);

  localparam int GID_W = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_n;
  logic [GID_W-1:0] grant_q, grant_n;
  logic [GID_W-1:0] rr_q, rr_n;
  logic [2:0]       op_q, op_n;
  logic             a_q, a_n;
  logic             b_q, b_n;
  logic             y_q, y_n;
  logic [N-1:0]     ack_q, ack_n;
  logic             busy_q, busy_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             win_vld;
  logic [GID_W-1:0] win_idx;
  logic             hi_vld;
  logic [GID_W-1:0] hi_idx;
  logic [GID_W-1:0] lo_idx;
  logic [2:0]       op_sel;
  logic             a_sel;
  logic             b_sel;
  logic [N-1:0]     grant_onehot;
  logic             unit_y;

  // Round-robin: lowest requester at or above rr_q wins, else wrap to the lowest overall.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    win_vld = 1'b0;
    lo_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld = 1'b1;
        lo_idx  = GID_W'(i);
        if (GID_W'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = GID_W'(i);
        end
      end
    end
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    op_sel = '0;
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (GID_W'(i) == win_idx) begin
        op_sel = bus.op[3*i +: 3];
        a_sel  = bus.a[i];
        b_sel  = bus.b[i];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < N; i++) begin
      grant_onehot[i] = (GID_W'(i) == grant_q);
    end
  end

  // The unit only ever sees the captured operands, so requesters may change theirs mid-flight.
  gate_mux8_unit u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y)
  );

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    rr_n    = rr_q;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    y_n     = y_q;
    ack_n   = ack_q;
    busy_n  = busy_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_n = win_idx;
          op_n    = op_sel;
          a_n     = a_sel;
          b_n     = b_sel;
          busy_n  = 1'b1;
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        y_n     = unit_y;
        ack_n   = grant_onehot;
        state_n = ST_ACK;
      end
      ST_ACK: begin
        ack_n   = '0;
        rr_n    = (grant_q == GID_W'(N - 1)) ? '0 : grant_q + GID_W'(1);
        cnt_n   = cnt_q + CNT_W'(1);
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: begin
        ack_n   = '0;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      rr_q    <= '0;
      op_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      y_q     <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_n;
      rr_q    <= rr_n;
      op_q    <= op_n;
      a_q     <= a_n;
      b_q     <= b_n;
      y_q     <= y_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
  assign bus.done_cnt = cnt_q;

endmodule
